instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Front-end stage that generates the program counter, issues single-outstanding instruction reads on a Wishbone-classic-style port, and buffers returned {pc, inst} pairs in a small queue. It drives the IF/ID pipeline register directly upstream of decode, with a valid/ready handshake. Decode-side stalls back-pressure the unit. EX/MEM-side redirects (branch, jump, trap) flush the unit.

## Interface
Parameters:
- DataSize, 64: PC/address width.
- ResetPc, 0: first fetch address after reset.
- QueueDepth, 2: fetch-queue entries (power of two, ≥2).

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- mem_rd_en  out  1  read request (cyc/stb); held until mem_ack.
- mem_addr  out  DataSize  request address; stable while mem_rd_en=1.
- mem_ack  in  1  read complete; mem_rd_dat is valid in the same cycle.
- mem_rd_dat  in  32  instruction word.
- flush  in  1  redirect request.
- new_pc  in  DataSize  redirect target, sampled when flush=1.
- id_ready  in  1  decode accepts this cycle.
- if_valid  out  1  queue head valid.
- if_pc  out  DataSize  head PC.
- if_inst  out  instruction_t  head instruction.
- fetch_misaligned  out  1  misaligned-target trap (see Configuration).
- fetch_badaddr  out  DataSize  offending target.

## Operation
- States: REQ (request outstanding), WAIT_SPACE (queue full, no request), DISCARD (stale request draining), TRAP (macro only).
- fetch_pc holds the address of the current or next request. On a retiring ack: fetch_pc += 4.
- Ack in REQ: the entry {fetch_pc, mem_rd_dat} is pushed.
  - Occupancy after this cycle's push/pop < QueueDepth: stay in REQ with the new address.
  - Otherwise: go to WAIT_SPACE with mem_rd_en=0.
- WAIT_SPACE → REQ on any pop (if_valid && id_ready).
- Pop: the head is dequeued when if_valid && id_ready.
- Push and pop in the same cycle are both honoured, and occupancy is unchanged.
- flush has top priority:
  - The queue is cleared and fetch_pc ← new_pc.
  - A same-cycle ack or pop is ignored and its data is dropped.
  - Request outstanding without an ack this cycle → DISCARD.
  - Otherwise → REQ.
- DISCARD: mem_rd_en and mem_addr keep the old request until mem_ack. The data is dropped, then → REQ at fetch_pc.
  - A flush during DISCARD updates fetch_pc only.
- Each response is associated only with the request that produced it; the pipeline never receives a stale instruction after a flush.

## Timing
- Reset values: mem_rd_en=0, mem_addr=ResetPc, if_valid=0, if_pc=0, if_inst=0, fetch_misaligned=0, fetch_badaddr=0, queue empty, state REQ, fetch_pc=ResetPc.
- First cycle after reset deasserts: mem_rd_en=1, mem_addr=ResetPc.
- All outputs are registered. Nothing combinational runs from mem_ack or id_ready to any output.
- Latency: ack in cycle k → if_valid=1 in cycle k+1 (queue was empty). The next address appears in cycle k+1.
- Flush in cycle k → if_valid=0 in cycle k+1. The new-target request appears in k+1, or after the stale ack when in DISCARD.
- Reset asserted mid-request abandons the request. The memory side must tolerate this.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A flush with new_pc[1:0]≠0 → TRAP. No request is issued.
  - fetch_misaligned=1 and fetch_badaddr=new_pc from the next cycle until the next flush.
  - The next flush with an aligned target → REQ and clears fetch_misaligned.
- FETCH_MISALIGN_TRAP_EN undefined:
  - new_pc[1:0] is treated as 00.
  - TRAP does not exist.
  - fetch_misaligned and fetch_badaddr are tied to 0.

## Structure
- Shared core package:
  - fetch_state_t enum.
  - fetch_entry_t packed struct {pc, inst}.
  - DataSize and instruction_t are reused.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, clear, full, empty, count, head.
  - Same asynchronous reset as the unit.

## Test plan
- Reset with ResetPc=0x1000, memory acking 1 cycle after each request, id_ready=1 → requests 0x1000, 0x1004, 0x1008. if_pc follows one cycle after each ack with the matching mem_rd_dat.
- id_ready=0 for 6 cycles → exactly 2 entries buffered (0x1000, 0x1004) and mem_rd_en=0 in WAIT_SPACE. The request for 0x1008 issues the cycle after id_ready rises.
- Flush to 0x2000 while a request for 0x1008 is outstanding, with ack 3 cycles later → the 0x1008 data is never presented. The next request is 0x2000 and the next if_pc is 0x2000.
- Flush coincident with an ack and a pop → the queue is empty next cycle. The acked data is dropped and the request goes to new_pc.
- With FETCH_MISALIGN_TRAP_EN: flush to 0x2002 → fetch_misaligned=1, fetch_badaddr=0x2002, no requests. A flush to 0x3000 clears the trap and fetches 0x3000.
- Reset asserted mid-request → all outputs return to their reset values asynchronously. Fetching restarts at ResetPc.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types for the instruction fetch unit: FSM states and queued {pc, inst} entries.
// The TRAP state exists only when FETCH_MISALIGN_TRAP_EN is defined.
package instruction_fetch_unit_pkg;

  localparam int DataSize = 64;

  typedef logic [31:0] instruction_t;

  typedef enum logic [1:0] {
    REQ        = 2'd0,
    WAIT_SPACE = 2'd1,
`ifdef FETCH_MISALIGN_TRAP_EN
    DISCARD    = 2'd2,
    TRAP       = 2'd3
`else
    DISCARD    = 2'd2
`endif
  } fetch_state_t;

  typedef struct packed {
    logic [DataSize-1:0] pc;
    instruction_t        inst;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Small synchronous FIFO of fetched {pc, inst} entries with a synchronous clear.
// Depth must be a power of two so the pointers wrap naturally.
import instruction_fetch_unit_pkg::*;

module fetch_queue #(
  parameter int Depth = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  fetch_entry_t           push_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] count,
  output fetch_entry_t           head
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  fetch_entry_t    r_mem [Depth];
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW-1:0] r_wr_ptr;
  logic [CntW-1:0] r_count;
  logic            w_do_pop;
  logic            w_do_push;

  assign empty     = (r_count == CntW'(0));
  assign full      = (r_count == CntW'(Depth));
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  // A push into a full queue is legal only when the head leaves in the same cycle.
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + PtrW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      r_count <= r_count + CntW'(w_do_push) - CntW'(w_do_pop);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: PC generation, single-outstanding memory reads, {pc, inst} queue toward decode.
// Define FETCH_MISALIGN_TRAP_EN to trap on misaligned redirect targets instead of masking them.
import instruction_fetch_unit_pkg::*;

module instruction_fetch_unit #(
  parameter int                  DataSize   = 64,
  parameter logic [DataSize-1:0] ResetPc    = '0,
  parameter int                  QueueDepth = 2
) (
  input  logic                clock,
  input  logic                reset,
  output logic                mem_rd_en,
  output logic [DataSize-1:0] mem_addr,
  input  logic                mem_ack,
  input  logic [31:0]         mem_rd_dat,
  input  logic                flush,
  input  logic [DataSize-1:0] new_pc,
  input  logic                id_ready,
  output logic                if_valid,
  output logic [DataSize-1:0] if_pc,
  output instruction_t        if_inst,
  output logic                fetch_misaligned,
  output logic [DataSize-1:0] fetch_badaddr
);

  localparam int CntW = $clog2(QueueDepth) + 1;

  fetch_state_t        r_state;
  logic [DataSize-1:0] r_fetch_pc;
  logic [DataSize-1:0] r_mem_addr;
  logic                r_mem_rd_en;
  logic [DataSize-1:0] w_target;
  logic                w_ack;
  logic                w_pop;
  logic                w_push;
  logic                w_room;
  logic                w_full;
  logic                w_empty;
  logic [CntW-1:0]     w_count;
  fetch_entry_t        w_push_entry;
  fetch_entry_t        w_head;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic                r_misaligned;
  logic [DataSize-1:0] r_badaddr;
  logic                w_misaligned;

  assign w_target         = new_pc;
  assign w_misaligned     = |new_pc[1:0];
  assign fetch_misaligned = r_misaligned;
  assign fetch_badaddr    = r_badaddr;
`else
  assign w_target         = new_pc & ~DataSize'(3);
  assign fetch_misaligned = 1'b0;
  assign fetch_badaddr    = '0;
`endif

  // A flush squashes any same-cycle ack or pop.
  assign w_ack        = r_mem_rd_en && mem_ack;
  assign w_pop        = !w_empty && id_ready && !flush;
  assign w_push       = (r_state == REQ) && w_ack && !flush && (!w_full || w_pop);
  assign w_room       = w_pop || (w_count < CntW'(QueueDepth - 1));
  assign w_push_entry = '{pc: r_fetch_pc, inst: mem_rd_dat};

  fetch_queue #(
    .Depth(QueueDepth)
  ) u_queue (
    .clock    (clock),
    .reset    (reset),
    .push     (w_push),
    .pop      (w_pop),
    .clear    (flush),
    .push_data(w_push_entry),
    .full     (w_full),
    .empty    (w_empty),
    .count    (w_count),
    .head     (w_head)
  );

  assign if_valid  = !w_empty;
  assign if_pc     = w_head.pc;
  assign if_inst   = w_head.inst;
  assign mem_rd_en = r_mem_rd_en;
  assign mem_addr  = r_mem_addr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= REQ;
      r_fetch_pc  <= ResetPc;
      r_mem_rd_en <= 1'b0;
      r_mem_addr  <= ResetPc;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_misaligned <= 1'b0;
      r_badaddr    <= '0;
`endif
    end else if (flush) begin
      r_fetch_pc <= w_target;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_misaligned <= w_misaligned;
      r_badaddr    <= w_misaligned ? new_pc : '0;
`endif
      // An unanswered request must drain before the bus can carry the new target.
      if (r_mem_rd_en && !mem_ack) begin
        r_state <= DISCARD;
      end else begin
        r_state     <= REQ;
        r_mem_rd_en <= 1'b1;
        r_mem_addr  <= w_target;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (w_misaligned) begin
          r_state     <= TRAP;
          r_mem_rd_en <= 1'b0;
        end
`endif
      end
    end else begin
      case (r_state)
        REQ: begin
          if (!r_mem_rd_en) begin
            r_mem_rd_en <= 1'b1;
            r_mem_addr  <= r_fetch_pc;
          end else if (mem_ack) begin
            r_fetch_pc <= r_fetch_pc + DataSize'(4);
            r_mem_addr <= r_fetch_pc + DataSize'(4);
            if (!w_room) begin
              r_state     <= WAIT_SPACE;
              r_mem_rd_en <= 1'b0;
            end
          end
        end
        WAIT_SPACE: begin
          if (w_pop) begin
            r_state     <= REQ;
            r_mem_rd_en <= 1'b1;
            r_mem_addr  <= r_fetch_pc;
          end
        end
        DISCARD: begin
          if (mem_ack) begin
            r_state     <= REQ;
            r_mem_rd_en <= 1'b1;
            r_mem_addr  <= r_fetch_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (r_misaligned) begin
              r_state     <= TRAP;
              r_mem_rd_en <= 1'b0;
            end
`endif
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        TRAP: begin
          r_mem_rd_en <= 1'b0;
        end
`endif
        default: begin
          r_state     <= REQ;
          r_mem_rd_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed vector table, corner sequences,
// and a randomized run against a stream-level model of the expected instruction sequence.
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_rd_en;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rd_dat;
  logic        flush;
  logic [63:0] new_pc;
  logic        id_ready;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_inst;
  logic        fetch_misaligned;
  logic [63:0] fetch_badaddr;

  int n_pass  = 0;
  int n_total = 0;
  int req_age = 0;
  int ack_lat = 1;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        exp_en;
    logic [63:0] exp_addr;
    logic        exp_valid;
    logic [63:0] exp_pc;
  } vec_t;

  vec_t vecs [14];

  instruction_fetch_unit #(
    .DataSize  (64),
    .ResetPc   (64'h1000),
    .QueueDepth(2)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .mem_rd_en       (mem_rd_en),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_rd_dat      (mem_rd_dat),
    .flush           (flush),
    .new_pc          (new_pc),
    .id_ready        (id_ready),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .fetch_misaligned(fetch_misaligned),
    .fetch_badaddr   (fetch_badaddr)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Memory responder: acks the visible request once it has waited ack_lat cycles.
  task automatic drive_mem();
    if (mem_rd_en) begin
      mem_ack    = (req_age >= ack_lat);
      mem_rd_dat = mem_ack ? inst_of(mem_addr) : 32'h0;
      req_age    = mem_ack ? 0 : req_age + 1;
    end else begin
      mem_ack    = 1'b0;
      mem_rd_dat = 32'h0;
      req_age    = 0;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_en"},      mem_rd_en, 64'd0);
    check({tag, "_addr"},    mem_addr, 64'h1000);
    check({tag, "_valid"},   if_valid, 64'd0);
    check({tag, "_pc"},      if_pc, 64'd0);
    check({tag, "_inst"},    if_inst, 64'd0);
    check({tag, "_mis"},     fetch_misaligned, 64'd0);
    check({tag, "_badaddr"}, fetch_badaddr, 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; id_ready = 1'b0; new_pc = 64'd0;
    mem_ack = 1'b0; mem_rd_dat = 32'd0; req_age = 0;
    tick();
    tick();
    check_reset_vals("reset");
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      drive_mem();
      tick();
      seen = if_valid;
    end
    check(name, seen, 64'd1);
  endtask

  initial begin
    bit          got;
    bit          prev_hold;
    bit          prev_flush;
    logic [63:0] prev_addr;
    logic [63:0] exp_next;
    logic [31:0] rlo;
    logic [31:0] rhi;
    int          pops;

    // Scenario A: steady fetch with id_ready=1; scenario B: decode stalled for 6 cycles.
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 64'h1000, 1'b0, 64'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 64'h1000, 1'b0, 64'h0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 64'h1004, 1'b1, 64'h1000};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 64'h1004, 1'b0, 64'h0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 64'h1008, 1'b1, 64'h1004};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 64'h1008, 1'b0, 64'h0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 64'h100C, 1'b1, 64'h1008};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 64'h1000, 1'b0, 64'h0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 64'h1000, 1'b0, 64'h0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 64'h1004, 1'b1, 64'h1000};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 64'h1004, 1'b1, 64'h1000};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 64'h0,    1'b1, 64'h1000};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 64'h0,    1'b1, 64'h1000};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 64'h1008, 1'b1, 64'h1004};

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].rst) do_reset();
      ack_lat = 1;
      drive_mem();
      id_ready = vecs[i].rdy;
      flush    = 1'b0;
      tick();
      check($sformatf("vec%0d_en", i), mem_rd_en, vecs[i].exp_en);
      if (vecs[i].exp_en) check($sformatf("vec%0d_addr", i), mem_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_valid", i), if_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_pc", i), if_pc, vecs[i].exp_pc);
        check($sformatf("vec%0d_inst", i), if_inst, inst_of(vecs[i].exp_pc));
      end
    end

    // Flush to 0x2000 while 0x1008 is outstanding; its ack arrives 3 cycles later.
    ack_lat = 3;
    drive_mem();
    flush = 1'b1; new_pc = 64'h2000;
    tick();
    flush = 1'b0;
    check("flush_valid", if_valid, 64'd0);
    check("discard_en", mem_rd_en, 64'd1);
    check("discard_addr", mem_addr, 64'h1008);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      drive_mem();
      got = mem_ack;
      tick();
      check("discard_no_valid", if_valid, 64'd0);
    end
    check("discard_ack_seen", got, 64'd1);
    check("redirect_en", mem_rd_en, 64'd1);
    check("redirect_addr", mem_addr, 64'h2000);
    ack_lat = 1;
    wait_valid("redirect_valid");
    check("redirect_pc", if_pc, 64'h2000);
    check("redirect_inst", if_inst, inst_of(64'h2000));

    // Flush coincident with an ack and a pop.
    ack_lat = 0;
    drive_mem();
    check("coinc_ack_present", mem_ack, 64'd1);
    id_ready = 1'b1; flush = 1'b1; new_pc = 64'h4000;
    tick();
    flush = 1'b0;
    check("coinc_valid", if_valid, 64'd0);
    check("coinc_en", mem_rd_en, 64'd1);
    check("coinc_addr", mem_addr, 64'h4000);
    ack_lat = 1;
    wait_valid("coinc_next_valid");
    check("coinc_next_pc", if_pc, 64'h4000);

    // Misaligned redirect target.
    drive_mem();
    flush = 1'b1; new_pc = 64'h2002;
    tick();
    flush = 1'b0;
    check("mis_flush_valid", if_valid, 64'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("trap_flag", fetch_misaligned, 64'd1);
    check("trap_badaddr", fetch_badaddr, 64'h2002);
    for (int i = 0; i < 6; i++) begin
      drive_mem();
      tick();
    end
    check("trap_no_req", mem_rd_en, 64'd0);
    check("trap_no_valid", if_valid, 64'd0);
    check("trap_flag_held", fetch_misaligned, 64'd1);
    drive_mem();
    flush = 1'b1; new_pc = 64'h3000;
    tick();
    flush = 1'b0;
    check("trap_clear", fetch_misaligned, 64'd0);
    wait_valid("trap_exit_valid");
    check("trap_exit_pc", if_pc, 64'h3000);
`else
    check("mis_flag_tied", fetch_misaligned, 64'd0);
    check("mis_badaddr_tied", fetch_badaddr, 64'd0);
    wait_valid("mis_masked_valid");
    check("mis_masked_pc", if_pc, 64'h2000);
`endif

    // Asynchronous reset in the middle of a request.
    check("pre_reset_en", mem_rd_en, 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("async");
    tick();
    reset = 1'b0; req_age = 0; mem_ack = 1'b0;
    drive_mem();
    id_ready = 1'b1;
    tick();
    check("restart_en", mem_rd_en, 64'd1);
    check("restart_addr", mem_addr, 64'h1000);

    // Randomized run: decode must see consecutive PCs from each redirect target.
    exp_next   = 64'h1000;
    prev_hold  = 1'b0;
    prev_addr  = 64'd0;
    pops       = 0;
    for (int c = 0; c < 3000; c++) begin
      if (req_age == 0) ack_lat = $urandom_range(0, 3);
      drive_mem();
      id_ready = ($urandom_range(0, 9) < 7);
      flush    = ($urandom_range(0, 29) == 0);
      rlo = $urandom;
      rhi = $urandom;
      new_pc = {rhi, rlo};
`ifdef FETCH_MISALIGN_TRAP_EN
      new_pc[1:0] = 2'b00;
`endif
      if (prev_hold) begin
        check("rand_hold_en", mem_rd_en, 64'd1);
        check("rand_hold_addr", mem_addr, prev_addr);
      end
      if (flush) begin
        exp_next = new_pc & ~64'h3;
      end else if (if_valid && id_ready) begin
        check("rand_pc", if_pc, exp_next);
        check("rand_inst", if_inst, inst_of(exp_next));
        exp_next = exp_next + 64'd4;
        pops++;
      end
      prev_hold  = mem_rd_en && !mem_ack;
      prev_addr  = mem_addr;
      prev_flush = flush;
      tick();
      if (prev_flush) check("rand_flush_valid", if_valid, 64'd0);
    end
    flush = 1'b0;
    check("rand_progress", (pops > 200), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
